regfile_wb_arbiter: RTL

- Owns the single register-file write port.
- Shares that port between two requesters:
  - the pipeline write-back stage, which never stalls and has fixed priority;
  - a long-latency auxiliary unit (mult/div, debug writes), which uses a valid/ready handshake.
- Auxiliary results are buffered in a small FIFO and drained in cycles where write-back does not write.
- An optional starvation mechanism asks the hazard unit for a bubble so queued results cannot wait forever.

---
 rtl/regfile_wb_arbiter_if.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Register-file write-port bus between the write-back/auxiliary side and the
// arbiter. The arbiter uses the slave modport; the requesters use master.
// Handshake: an auxiliary entry transfers on the rising edge where
// i_aux_valid && o_aux_ready; o_aux_ready comes from registered state only,
// and the requester holds valid/address/data stable while ready is low.
interface regfile_wb_arbiter_if #(
   parameter int BITS_SIZE  = 32,
   parameter int BITS_REGS  = 5,
   parameter int FIFO_DEPTH = 2
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                 i_wb_reg_write;
   logic [BITS_REGS-1:0] i_wb_register_addr;
   logic [BITS_SIZE-1:0] i_wb_data;
   logic                 i_aux_valid;
   logic                 o_aux_ready;
   logic [BITS_REGS-1:0] i_aux_register_addr;
   logic [BITS_SIZE-1:0] i_aux_data;
   logic                 o_rf_write_en;
   logic [BITS_REGS-1:0] o_rf_addr;
   logic [BITS_SIZE-1:0] o_rf_data;
   logic                 o_stall_request;
   logic [CNT_W-1:0]     o_pending_count;
   logic [1:0]           state_dbg;

   modport slave (
      input  i_wb_reg_write, i_wb_register_addr, i_wb_data,
      input  i_aux_valid, i_aux_register_addr, i_aux_data,
      output o_aux_ready, o_rf_write_en, o_rf_addr, o_rf_data,
      output o_stall_request, o_pending_count, state_dbg
   );

   modport master (
      output i_wb_reg_write, i_wb_register_addr, i_wb_data,
      output i_aux_valid, i_aux_register_addr, i_aux_data,
      input  o_aux_ready, o_rf_write_en, o_rf_addr, o_rf_data,
      input  o_stall_request, o_pending_count, state_dbg
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter. Write-back has fixed priority; auxiliary
// results are queued in a small FIFO and drained in cycles without a live
// write-back. Optional starvation relief (stall request / FORCE state) is
// built only when REGFILE_ARB_STARVE_EN is defined.
module regfile_wb_arbiter #(
   parameter int BITS_SIZE    = 32,
   parameter int BITS_REGS    = 5,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   regfile_wb_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      FORCE   = 2'd2
   } state_t;

   state_t               state;
   logic [BITS_REGS-1:0] mem_addr [FIFO_DEPTH];
   logic [BITS_SIZE-1:0] mem_data [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     count_next;
   logic                 wb_live;
   logic                 empty;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 stall_q;

   // A write-back to register 0 is treated as no request at all.
   assign wb_live    = bus.i_wb_reg_write && (bus.i_wb_register_addr != '0);
   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign push       = bus.i_aux_valid && !full;
   assign pop        = !wb_live && !empty;
   assign count_next = count + CNT_W'(push) - CNT_W'(pop);

   assign bus.o_aux_ready     = !full;
   assign bus.o_pending_count = count;
   assign bus.state_dbg       = state;

`ifdef REGFILE_ARB_STARVE_EN
   logic [3:0] starve_cnt;
   logic [3:0] starve_next;

   assign bus.o_stall_request = stall_q;

   // Count cycles a queued head loses to write-back; any pop or an empty FIFO clears it.
   always_comb begin
      starve_next = starve_cnt;
      if (pop || empty)
         starve_next = '0;
      else if (wb_live && (starve_cnt != 4'(STARVE_LIMIT)))
         starve_next = starve_cnt + 4'd1;
   end
`else
   assign bus.o_stall_request = 1'b0;
`endif

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_addr[wr_ptr] <= bus.i_aux_register_addr;
         mem_data[wr_ptr] <= bus.i_aux_data;
      end
   end

   // Pointers, occupancy, registered write port and the control FSM.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state             <= IDLE;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         bus.o_rf_write_en <= 1'b0;
         bus.o_rf_addr     <= '0;
         bus.o_rf_data     <= '0;
         stall_q           <= 1'b0;
`ifdef REGFILE_ARB_STARVE_EN
         starve_cnt        <= '0;
`endif
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         count  <= count_next;
`ifdef REGFILE_ARB_STARVE_EN
         starve_cnt <= starve_next;
`endif

         if (wb_live) begin
            bus.o_rf_write_en <= 1'b1;
            bus.o_rf_addr     <= bus.i_wb_register_addr;
            bus.o_rf_data     <= bus.i_wb_data;
         end else if (pop) begin
            bus.o_rf_write_en <= (mem_addr[rd_ptr] != '0);
            bus.o_rf_addr     <= mem_addr[rd_ptr];
            bus.o_rf_data     <= mem_data[rd_ptr];
         end else begin
            bus.o_rf_write_en <= 1'b0;
         end

         case (state)
            IDLE: begin
               stall_q <= 1'b0;
               if (count_next != '0)
                  state <= PENDING;
            end
            PENDING: begin
               if (count_next == '0)
                  state <= IDLE;
`ifdef REGFILE_ARB_STARVE_EN
               else if (starve_next == 4'(STARVE_LIMIT)) begin
                  state   <= FORCE;
                  stall_q <= 1'b1;
               end
`endif
            end
            FORCE: begin
               if (pop) begin
                  stall_q <= 1'b0;
                  state   <= (count_next == '0) ? IDLE : PENDING;
               end
            end
            default: begin
               stall_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   logic wb_hazard;

   // A live write-back must never target a register that still has a queued entry.
   always_comb begin
      wb_hazard = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (wb_live &&
             (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count) &&
             (mem_addr[i] == bus.i_wb_register_addr))
            wb_hazard = 1'b1;
      end
   end

   // Flag write-back/auxiliary ordering violations on each edge.
   always @(posedge i_clk) begin
      if (i_rst_n)
         assert (!wb_hazard) else $error("write-back hits queued register %0d", bus.i_wb_register_addr);
   end
`endif
endmodule
